// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: cpu bus command encodings,
// default register addresses and the service FSM state encoding.
package irq_ctrl_pkg;

    // cpu memory command encodings as driven on mem_cmd
    typedef enum logic [1:0] {
        MNONE  = 2'd0,
        MREAD  = 2'd1,
        MWRITE = 2'd2
    } mem_cmd_e;

    // Default memory-mapped register addresses
    localparam logic [8:0] MASK_ADDR_DEF = 9'h1F0;
    localparam logic [8:0] STAT_ADDR_DEF = 9'h1F1;
    localparam logic [8:0] EOI_ADDR_DEF  = 9'h1F2;

    // Service sequence: wait, pulse isr, wait for EOI, pulse main
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTER = 2'd1,
        SVC   = 2'd2,
        EXIT  = 2'd3
    } irq_state_e;

endpackage

// File: rtl/irq_sync.sv
// One interrupt line: two-flop synchroniser for the asynchronous key input,
// followed by a registered rising-edge detector on the second stage.
module irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_rise;

    // Synchronise the raw line and emit a one-cycle pulse on each 0->1 transition
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge
            // value of its neighbour; blocking here would collapse the chain.
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_rise  <= r_sync2 & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/irq_ctrl.sv
// Upstream interrupt controller for the cpu. Latches synchronised rising
// edges as pending, services the lowest-numbered enabled pending line with a
// one-cycle isr pulse, and on an EOI write releases the line and pulses main.
// Registers are reached by snooping the cpu RAM bus.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int         NIRQ      = 4,
    parameter logic [8:0] MASK_ADDR = MASK_ADDR_DEF,
    parameter logic [8:0] STAT_ADDR = STAT_ADDR_DEF,
    parameter logic [8:0] EOI_ADDR  = EOI_ADDR_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq_raw,
    input  logic [8:0]      mem_addr,
    input  logic [1:0]      mem_cmd,
    input  logic [15:0]     wr_data,
    output logic [15:0]     rd_data,
    output logic            rd_hit,
    output logic            isr,
    output logic            main,
    output logic [2:0]      irq_id,
    output logic            in_svc
);

    logic [NIRQ-1:0] w_rise;
    logic [NIRQ-1:0] w_eligible;
    logic [NIRQ-1:0] w_clr;
    logic [2:0]      w_winner;
    logic            w_any;
    logic            w_mask_wr;
    logic            w_eoi_wr;
    logic            w_unused_wr_data;

    logic [NIRQ-1:0] r_mask;
    logic [NIRQ-1:0] r_pending;
    irq_state_e      r_state;
    logic [2:0]      r_irq_id;
    logic            r_isr;
    logic            r_main;
    logic            r_in_svc;

    // Per-line synchroniser and edge detector
    for (genvar g = 0; g < NIRQ; g++) begin : g_line
        irq_sync u_sync (
            .clk    (clk),
            .reset  (reset),
            .i_raw  (irq_raw[g]),
            .o_rise (w_rise[g])
        );
    end

    assign w_mask_wr  = (mem_cmd == MWRITE) && (mem_addr == MASK_ADDR);
    assign w_eoi_wr   = (mem_cmd == MWRITE) && (mem_addr == EOI_ADDR);
    assign w_eligible = r_pending & r_mask;
    assign w_any      = |w_eligible;

    // Only the mask bits of the write data are stored
    assign w_unused_wr_data = ^wr_data[15:NIRQ];

    // Priority encoder: the lowest eligible index wins
    always_comb begin
        // NOTE: a default before the loop keeps every path assigned, so no latch
        // is inferred when nothing is eligible.
        w_winner = 3'd0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = 3'(i);
            end
        end
    end

    // Pending bit to release when the in-service line is acknowledged
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NIRQ; i++) begin
            w_clr[i] = (r_state == SVC) && w_eoi_wr && (r_irq_id == 3'(i));
        end
    end

    // Pending latch: a fresh edge overrides a simultaneous EOI release
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_rise;
        end
    end

    // Mask register, written from the snooped bus
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '0;
        end else if (w_mask_wr) begin
            r_mask <= wr_data[NIRQ-1:0];
        end
    end

    // Service FSM with registered isr/main/in_svc/irq_id outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_irq_id <= 3'd0;
            r_isr    <= 1'b0;
            r_main   <= 1'b0;
            r_in_svc <= 1'b0;
        end else begin
            r_isr  <= 1'b0;
            r_main <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state  <= ENTER;
                        r_irq_id <= w_winner;
                        r_isr    <= 1'b1;
                        r_in_svc <= 1'b1;
                    end
                end
                ENTER: begin
                    r_state <= SVC;
                end
                SVC: begin
                    if (w_eoi_wr) begin
                        r_state  <= EXIT;
                        r_main   <= 1'b1;
                        r_in_svc <= 1'b0;
                    end
                end
                EXIT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Combinational register read-back on the snooped bus
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = 16'h0000;
        if (mem_cmd == MREAD) begin
            if (mem_addr == MASK_ADDR) begin
                rd_hit               = 1'b1;
                rd_data[NIRQ-1:0]    = r_mask;
            end else if (mem_addr == STAT_ADDR) begin
                rd_hit               = 1'b1;
                rd_data[15]          = r_in_svc;
                rd_data[10:8]        = r_irq_id;
                rd_data[NIRQ-1:0]    = r_pending;
            end
        end
    end

    assign isr    = r_isr;
    assign main   = r_main;
    assign irq_id = r_irq_id;
    assign in_svc = r_in_svc;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model of the controller.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    localparam int         NIRQ   = 4;
    localparam logic [8:0] MASK_A = 9'h1F0;
    localparam logic [8:0] STAT_A = 9'h1F1;
    localparam logic [8:0] EOI_A  = 9'h1F2;

    logic            clk = 1'b0;
    logic            reset;
    logic [NIRQ-1:0] irq_raw;
    logic [8:0]      mem_addr;
    logic [1:0]      mem_cmd;
    logic [15:0]     wr_data;
    logic [15:0]     rd_data;
    logic            rd_hit;
    logic            isr;
    logic            main;
    logic [2:0]      irq_id;
    logic            in_svc;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: phase 0 idle, 1 isr cycle, 2 in service, 3 main cycle
    logic [NIRQ-1:0] m_pend;
    logic [NIRQ-1:0] m_mask;
    logic [NIRQ-1:0] m_prev;
    logic [NIRQ-1:0] m_dly [3];
    int              m_phase;
    int              m_id;

    irq_ctrl #(.NIRQ(NIRQ)) dut (
        .clk      (clk),
        .reset    (reset),
        .irq_raw  (irq_raw),
        .mem_addr (mem_addr),
        .mem_cmd  (mem_cmd),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .rd_hit   (rd_hit),
        .isr      (isr),
        .main     (main),
        .irq_id   (irq_id),
        .in_svc   (in_svc)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic int lowest(input logic [NIRQ-1:0] v);
        for (int i = 0; i < NIRQ; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic exp_in_svc();
        return (m_phase == 1) || (m_phase == 2);
    endfunction

    function automatic logic exp_rd_hit();
        return (mem_cmd == MREAD) && ((mem_addr == MASK_A) || (mem_addr == STAT_A));
    endfunction

    function automatic logic [15:0] exp_rd_data();
        logic [15:0] v;
        v = 16'h0000;
        if (mem_cmd == MREAD && mem_addr == MASK_A) begin
            v[NIRQ-1:0] = m_mask;
        end else if (mem_cmd == MREAD && mem_addr == STAT_A) begin
            v[15]        = exp_in_svc();
            v[10:8]      = 3'(m_id);
            v[NIRQ-1:0]  = m_pend;
        end
        return v;
    endfunction

    // One clock: drive at the falling edge, advance the model at the rising
    // edge, return 1 time unit later so outputs can be sampled
    task automatic step(input logic rst, input logic [NIRQ-1:0] raw,
                        input logic [1:0] cmd, input logic [8:0] addr,
                        input logic [15:0] data);
        logic [NIRQ-1:0] applied;
        logic [NIRQ-1:0] elig;
        logic [NIRQ-1:0] clr;
        logic            eoi;
        @(negedge clk);
        reset    = rst;
        irq_raw  = raw;
        mem_cmd  = cmd;
        mem_addr = addr;
        wr_data  = data;
        @(posedge clk);
        if (rst) begin
            m_pend  = '0;
            m_mask  = '0;
            m_prev  = '0;
            m_dly[0] = '0;
            m_dly[1] = '0;
            m_dly[2] = '0;
            m_phase = 0;
            m_id    = 0;
        end else begin
            // A rise sampled at edge n becomes pending at edge n+3
            applied  = m_dly[2];
            m_dly[2] = m_dly[1];
            m_dly[1] = m_dly[0];
            m_dly[0] = raw & ~m_prev;
            m_prev   = raw;
            elig     = m_pend & m_mask;
            clr      = '0;
            eoi      = (cmd == MWRITE) && (addr == EOI_A);
            case (m_phase)
                0: if (elig != '0) begin m_id = lowest(elig); m_phase = 1; end
                1: m_phase = 2;
                2: if (eoi) begin clr[m_id] = 1'b1; m_phase = 3; end
                default: m_phase = 0;
            endcase
            if (cmd == MWRITE && addr == MASK_A) m_mask = data[NIRQ-1:0];
            m_pend = (m_pend & ~clr) | applied;
        end
        #1;
    endtask

    task automatic stat_step(input logic [NIRQ-1:0] raw);
        step(1'b0, raw, MREAD, STAT_A, 16'h0000);
    endtask

    task automatic eoi_step(input logic [NIRQ-1:0] raw);
        step(1'b0, raw, MWRITE, EOI_A, 16'hBEEF);
    endtask

    task automatic mask_step(input logic [NIRQ-1:0] raw, input logic [15:0] v);
        step(1'b0, raw, MWRITE, MASK_A, v);
    endtask

    task automatic do_reset();
        step(1'b1, '0, MNONE, 9'h000, 16'h0000);
        step(1'b1, '0, MNONE, 9'h000, 16'h0000);
    endtask

    // Steps until isr is seen or the cycle budget runs out
    task automatic wait_isr(input logic [NIRQ-1:0] raw, output bit found);
        found = 1'b0;
        for (int c = 0; c < 12 && !found; c++) begin
            stat_step(raw);
            if (isr === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        step(1'b1, 4'b1111, MREAD, MASK_A, 16'h0000);
        step(1'b1, 4'b1111, MREAD, MASK_A, 16'h0000);
        n_tests++;
        if ({isr, main, in_svc, irq_id} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got isr=%b main=%b in_svc=%b id=%0d, required all 0",
                     isr, main, in_svc, irq_id);
        end
        n_tests++;
        if (rd_hit !== 1'b1 || rd_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mask: got hit=%b data=%h, required hit=1 data=0000", rd_hit, rd_data);
        end
        step(1'b0, '0, MREAD, STAT_A, 16'h0000);
        n_tests++;
        if (rd_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_stat: got %h, required 0000", rd_data);
        end
    endtask

    task automatic test_mask_pending();
        bit seen = 1'b0;
        do_reset();
        stat_step(4'b0100);
        for (int c = 0; c < 6; c++) begin
            stat_step(4'b0000);
            if (isr !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (rd_data[3:0] !== 4'b0100) begin
            n_fail++;
            $display("FAIL masked_pending: got pending=%b, required 0100", rd_data[3:0]);
        end
        n_tests++;
        if (seen || in_svc !== 1'b0) begin
            n_fail++;
            $display("FAIL masked_no_isr: got isr_seen=%0b in_svc=%b, required 0 0", seen, in_svc);
        end
    endtask

    task automatic test_single_service();
        do_reset();
        mask_step(4'b0000, 16'h000F);
        stat_step(4'b0010);
        for (int c = 1; c <= 5; c++) begin
            stat_step(4'b0010);
            n_tests++;
            if (isr !== (c == 4)) begin
                n_fail++;
                $display("FAIL isr_latency k+%0d: got isr=%b, required %b", c, isr, (c == 4));
            end
            if (c == 4) begin
                n_tests++;
                if (irq_id !== 3'd1 || in_svc !== 1'b1) begin
                    n_fail++;
                    $display("FAIL svc_line1: got id=%0d in_svc=%b, required 1 1", irq_id, in_svc);
                end
            end
        end
        eoi_step(4'b0010);
        n_tests++;
        if (main !== 1'b1) begin
            n_fail++;
            $display("FAIL eoi_main: got main=%b, required 1", main);
        end
        stat_step(4'b0010);
        n_tests++;
        if (main !== 1'b0 || isr !== 1'b0) begin
            n_fail++;
            $display("FAIL main_one_cycle: got main=%b isr=%b, required 0 0", main, isr);
        end
    endtask

    task automatic test_priority();
        bit found;
        do_reset();
        mask_step(4'b0000, 16'h000F);
        stat_step(4'b1001);
        wait_isr(4'b1001, found);
        n_tests++;
        if (!found || irq_id !== 3'd0) begin
            n_fail++;
            $display("FAIL prio_first: got found=%0b id=%0d, required 1 0", found, irq_id);
        end
        stat_step(4'b1001);
        eoi_step(4'b1001);
        n_tests++;
        if (main !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_main: got main=%b, required 1", main);
        end
        stat_step(4'b1001);
        n_tests++;
        if (isr !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_gap: got isr=%b one cycle after main, required 0", isr);
        end
        stat_step(4'b1001);
        n_tests++;
        if (isr !== 1'b1 || irq_id !== 3'd3) begin
            n_fail++;
            $display("FAIL prio_second: got isr=%b id=%0d, required 1 3", isr, irq_id);
        end
    endtask

    task automatic test_eoi_collision();
        bit found;
        do_reset();
        mask_step(4'b0000, 16'h000F);
        stat_step(4'b0010);
        wait_isr(4'b0010, found);
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL coll_wait_isr: got no isr, required isr within budget");
        end
        repeat (3) stat_step(4'b0000);
        stat_step(4'b0010);
        stat_step(4'b0010);
        stat_step(4'b0010);
        eoi_step(4'b0010);
        n_tests++;
        if (main !== 1'b1) begin
            n_fail++;
            $display("FAIL coll_main: got main=%b, required 1", main);
        end
        stat_step(4'b0010);
        n_tests++;
        if (rd_data[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL coll_pending: got pending[1]=%b, required 1", rd_data[1]);
        end
        stat_step(4'b0010);
        n_tests++;
        if (isr !== 1'b1 || irq_id !== 3'd1) begin
            n_fail++;
            $display("FAIL coll_refire: got isr=%b id=%0d, required 1 1", isr, irq_id);
        end
    endtask

    task automatic test_eoi_idle_and_reset();
        bit found;
        do_reset();
        stat_step(4'b0100);
        repeat (5) stat_step(4'b0000);
        n_tests++;
        if (rd_data !== 16'h0004) begin
            n_fail++;
            $display("FAIL idle_stat_before: got %h, required 0004", rd_data);
        end
        eoi_step(4'b0000);
        n_tests++;
        if (main !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_eoi_main: got main=%b, required 0", main);
        end
        stat_step(4'b0000);
        n_tests++;
        if (rd_data !== 16'h0004 || main !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_eoi_stat: got stat=%h main=%b, required 0004 0", rd_data, main);
        end
        mask_step(4'b0000, 16'h000F);
        wait_isr(4'b0000, found);
        n_tests++;
        if (!found || irq_id !== 3'd2) begin
            n_fail++;
            $display("FAIL rst_svc_start: got found=%0b id=%0d, required 1 2", found, irq_id);
        end
        stat_step(4'b0000);
        step(1'b1, 4'b0000, MREAD, MASK_A, 16'h0000);
        n_tests++;
        if (in_svc !== 1'b0 || main !== 1'b0 || rd_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_mid_svc: got in_svc=%b main=%b mask=%h, required 0 0 0000",
                     in_svc, main, rd_data);
        end
        stat_step(4'b0000);
        n_tests++;
        if (rd_data !== 16'h0000 || main !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after: got stat=%h main=%b, required 0000 0", rd_data, main);
        end
    endtask

    task automatic test_reads();
        do_reset();
        mask_step(4'b0000, 16'h000A);
        step(1'b0, 4'b0000, MREAD, MASK_A, 16'h0000);
        n_tests++;
        if (rd_hit !== 1'b1 || rd_data !== 16'h000A) begin
            n_fail++;
            $display("FAIL read_mask: got hit=%b data=%h, required 1 000A", rd_hit, rd_data);
        end
        step(1'b0, 4'b0000, MREAD, 9'h010, 16'h0000);
        n_tests++;
        if (rd_hit !== 1'b0 || rd_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL read_other: got hit=%b data=%h, required 0 0000", rd_hit, rd_data);
        end
        step(1'b0, 4'b0000, MNONE, MASK_A, 16'h0000);
        n_tests++;
        if (rd_hit !== 1'b0 || rd_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL read_no_cmd: got hit=%b data=%h, required 0 0000", rd_hit, rd_data);
        end
    endtask

    task automatic test_random();
        logic [NIRQ-1:0] raw;
        logic [1:0]      cmd;
        logic [8:0]      addr;
        logic [15:0]     data;
        logic            rst;
        int              r;
        do_reset();
        raw = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NIRQ; i++) begin
                if ($urandom_range(0, 11) == 0) raw[i] = ~raw[i];
            end
            rst  = ($urandom_range(0, 499) == 0);
            r    = int'($urandom_range(0, 99));
            data = 16'($urandom);
            addr = 9'($urandom);
            if (r < 10)      begin cmd = MWRITE; addr = EOI_A;  end
            else if (r < 13) begin cmd = MWRITE; addr = MASK_A; end
            else if (r < 60) begin cmd = MREAD;  addr = STAT_A; end
            else if (r < 75) begin cmd = MREAD;  addr = MASK_A; end
            else if (r < 85) begin cmd = MREAD;                 end
            else             begin cmd = MNONE;                 end
            step(rst, raw, cmd, addr, data);
            n_tests++;
            if (isr !== (m_phase == 1) || main !== (m_phase == 3) || in_svc !== exp_in_svc()) begin
                n_fail++;
                $display("FAIL rand_ctrl cyc %0d: got isr=%b main=%b in_svc=%b, required %b %b %b",
                         c, isr, main, in_svc, (m_phase == 1), (m_phase == 3), exp_in_svc());
            end
            if (exp_in_svc()) begin
                n_tests++;
                if (irq_id !== 3'(m_id)) begin
                    n_fail++;
                    $display("FAIL rand_id cyc %0d: got %0d, required %0d", c, irq_id, m_id);
                end
            end
            n_tests++;
            if (rd_hit !== exp_rd_hit() || rd_data !== exp_rd_data()) begin
                n_fail++;
                $display("FAIL rand_read cyc %0d: got hit=%b data=%h, required %b %h",
                         c, rd_hit, rd_data, exp_rd_hit(), exp_rd_data());
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        irq_raw  = '0;
        mem_addr = 9'h000;
        mem_cmd  = MNONE;
        wr_data  = 16'h0000;
        test_reset();
        test_mask_pending();
        test_single_service();
        test_priority();
        test_eoi_collision();
        test_eoi_idle_and_reset();
        test_reads();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
